// File: rtl/agenda_llamadas_if.sv
// Signal bundle between the call scheduler and whoever plays the callees.
interface agenda_llamadas_if;
  logic       start;
  logic       ack;
  logic       resp;
  logic       call;
  logic [1:0] who;
  logic [3:0] sel;
  logic       busy;
  logic       done;
  logic       ok;
  logic       fail;
  logic [2:0] state;

  // Handshake: call is the request and stays high, with who stable, until the
  // cycle in which ack=1 is sampled; resp is only meaningful in that cycle.
  // start is only honoured while busy=0; done pulses once when a search ends.
  modport master (
    output start, ack, resp,
    input  call, who, sel, busy, done, ok, fail, state
  );

  modport slave (
    input  start, ack, resp,
    output call, who, sel, busy, done, ok, fail, state
  );
endinterface

// File: rtl/agenda_llamadas.sv
// Searches candidate invitation sets in ascending order and phones every
// invitee of each valid set, lowest index first, until one set is fully accepted.
module agenda_llamadas (
  input  logic              clk,
  input  logic              reset_n,
  agenda_llamadas_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CHECK, CALL, GAP, NEXT, DONE} state_t;

  state_t     state;
  logic       call_q;
  logic [1:0] who_q;
  logic [3:0] sel_q;
  logic       busy_q;
  logic       done_q;
  logic       ok_q;
  logic       fail_q;

  logic [1:0] low_idx;
  logic [1:0] up_idx;
  logic       up_found;

  // Bit order of sel is {d, c, b, a}.
  function automatic logic is_valid(input logic [3:0] s);
    logic a, b, c, d;
    a = s[0];
    b = s[1];
    c = s[2];
    d = s[3];
    return (|s) && !(&s) && (!b || c) && (!(a && c) || b || d) && (!(c || d || !a) || b);
  endfunction

  // Descending scans so the last hit is the lowest qualifying bit.
  always_comb begin
    low_idx  = 2'd0;
    up_idx   = 2'd0;
    up_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (sel_q[i]) low_idx = 2'(i);
      if (sel_q[i] && (i > int'(who_q))) begin
        up_idx   = 2'(i);
        up_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      call_q <= 1'b0;
      who_q  <= 2'd0;
      sel_q  <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= CHECK;
            sel_q  <= 4'b0001;
            ok_q   <= 1'b0;
            fail_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        CHECK: begin
          if (is_valid(sel_q)) begin
            state  <= CALL;
            call_q <= 1'b1;
            who_q  <= low_idx;
          end else begin
            state <= NEXT;
          end
        end
        CALL: begin
          if (bus.ack) begin
            call_q <= 1'b0;
            if (!bus.resp) begin
              state <= NEXT;
            end else if (up_found) begin
              // who moves on during GAP, while call is low.
              state <= GAP;
              who_q <= up_idx;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
              ok_q   <= 1'b1;
            end
          end
        end
        GAP: begin
          state  <= CALL;
          call_q <= 1'b1;
        end
        NEXT: begin
          if (sel_q == 4'b1111) begin
            state  <= DONE;
            done_q <= 1'b1;
            fail_q <= 1'b1;
          end else begin
            sel_q <= sel_q + 4'd1;
            state <= CHECK;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.call  = call_q;
  assign bus.who   = who_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ok    = ok_q;
  assign bus.fail  = fail_q;
  assign bus.state = state;

endmodule

// File: tb/tb_agenda_llamadas.sv
// Bench for agenda_llamadas: a search-level trace generator fills an expected
// queue cycle by cycle, and one compare process checks every output each cycle.
module tb_agenda_llamadas;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  agenda_llamadas_if bus ();

  agenda_llamadas dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Expected entry layout: {busy, call, who, sel, done, ok, fail}
  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_n    = 0;
  logic        prev_call = 1'b0;
  int          rise_t[$];
  logic [3:0]  rise_sel[$];
  logic [1:0]  rise_who[$];
  int          done_t[$];
  logic        ans_q[$];
  logic [3:0]  m_sel  = 4'd0;
  logic        m_ok   = 1'b0;
  logic        m_fail = 1'b0;
  int          t0     = 0;

  function automatic logic [10:0] ent(input logic b, input logic c, input logic [1:0] w,
                                      input logic [3:0] s, input logic d, input logic o,
                                      input logic f);
    return {b, c, w, s, d, o, f};
  endfunction

  // The four acceptable invitation sets, listed rather than derived.
  function automatic logic good_set(input logic [3:0] s);
    return (s == 4'b0001) || (s == 4'b0110) || (s == 4'b0111) || (s == 4'b1110);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  always @(negedge clk) begin
    logic [10:0] act;
    logic [10:0] e;
    if (reset_n === 1'b1) begin
      act = {bus.busy, bus.call, (bus.call ? bus.who : 2'b00), bus.sel, bus.done, bus.ok, bus.fail};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL cycle %0d outputs {busy,call,who,sel,done,ok,fail}: got %03h expected %03h",
                      cyc_n, act, e);
      end
      if (bus.call && !prev_call) begin
        rise_t.push_back(cyc_n);
        rise_sel.push_back(bus.sel);
        rise_who.push_back(bus.who);
      end
      if (bus.done) done_t.push_back(cyc_n);
      prev_call = bus.call;
    end else begin
      prev_call = 1'b0;
    end
    cyc_n++;
  end

  task automatic cyc(input logic st, input logic ak, input logic rp, input logic [10:0] e);
    bus.start = st;
    bus.ack   = ak;
    bus.resp  = rp;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, rb(), rb(), ent(1'b0, 1'b0, 2'd0, m_sel, 1'b0, m_ok, m_fail));
  endtask

  task automatic clear_log();
    rise_t.delete();
    rise_sel.delete();
    rise_who.delete();
    done_t.delete();
  endtask

  // Plays one whole search; answers come from ans_q first, then at random.
  task automatic run_search(input int accept_pct, input int max_delay);
    logic       fin;
    logic       r;
    logic       first;
    logic [3:0] s;
    int         d;
    t0 = cyc_n;
    cyc(1'b1, rb(), rb(), ent(1'b0, 1'b0, 2'd0, m_sel, 1'b0, m_ok, m_fail));
    m_ok   = 1'b0;
    m_fail = 1'b0;
    fin    = 1'b0;
    s      = 4'd1;
    while (!fin) begin
      cyc(rb(), rb(), rb(), ent(1'b1, 1'b0, 2'd0, s, 1'b0, 1'b0, 1'b0));
      r = 1'b0;
      if (good_set(s)) begin
        r     = 1'b1;
        first = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (s[i] && r) begin
            if (!first) cyc(rb(), rb(), rb(), ent(1'b1, 1'b0, 2'd0, s, 1'b0, 1'b0, 1'b0));
            first = 1'b0;
            d = int'($urandom_range(0, max_delay));
            for (int j = 0; j < d; j++)
              cyc(rb(), 1'b0, rb(), ent(1'b1, 1'b1, 2'(i), s, 1'b0, 1'b0, 1'b0));
            if (ans_q.size() > 0) r = ans_q.pop_front();
            else r = (int'($urandom_range(0, 99)) < accept_pct);
            cyc(rb(), 1'b1, r, ent(1'b1, 1'b1, 2'(i), s, 1'b0, 1'b0, 1'b0));
          end
        end
      end
      if (r) begin
        cyc(rb(), rb(), rb(), ent(1'b1, 1'b0, 2'd0, s, 1'b1, 1'b1, 1'b0));
        m_ok = 1'b1;
        fin  = 1'b1;
      end else begin
        cyc(rb(), rb(), rb(), ent(1'b1, 1'b0, 2'd0, s, 1'b0, 1'b0, 1'b0));
        if (s == 4'hF) begin
          cyc(rb(), rb(), rb(), ent(1'b1, 1'b0, 2'd0, s, 1'b1, 1'b0, 1'b1));
          m_fail = 1'b1;
          fin    = 1'b1;
        end else begin
          s = s + 4'd1;
        end
      end
    end
    m_sel = s;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {21'd0, bus.call, bus.who, bus.sel, bus.busy, bus.done, bus.ok, bus.fail}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    bus.resp  = 1'b0;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk_reset_outputs("reset_before_clk");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // Immediate acceptance by Ana.
    clear_log();
    ans_q = '{1'b1};
    run_search(100, 0);
    idle(1);
    chk("t028_call_count", rise_t.size(), 1);
    chk("t028_call_at_t2", rise_t[0] - t0, 2);
    chk("t028_done_at_t3", done_t[0] - t0, 3);
    chk("t028_idle_sel_ok_fail", {28'd0, bus.busy, bus.sel == 4'b0001, bus.ok, bus.fail}, 32'h6);

    // Ana declines, then Bea and Carmen accept.
    clear_log();
    ans_q = '{1'b0, 1'b1, 1'b1};
    run_search(100, 0);
    idle(1);
    chk("t029_call_count", rise_t.size(), 3);
    chk("t029_call2_at_t13", rise_t[1] - t0, 13);
    chk("t029_call2_sel", rise_sel[1], 4'b0110);
    chk("t029_call2_who", rise_who[1], 2'd1);
    chk("t030_call3_at_t15", rise_t[2] - t0, 15);
    chk("t030_call3_who", rise_who[2], 2'd2);
    chk("t030_done_at_t16", done_t[0] - t0, 16);
    chk("t030_final_sel", bus.sel, 4'b0110);

    // Everybody declines.
    clear_log();
    ans_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_search(0, 1);
    idle(1);
    chk("t031_call_count", rise_sel.size(), 4);
    chk("t031_call_sels", {rise_sel[0], rise_sel[1], rise_sel[2], rise_sel[3]}, 16'h167E);
    chk("t031_ok_fail_sel", {27'd0, bus.ok, bus.fail, bus.sel}, 32'h1F);

    // Reset while a call is outstanding.
    clear_log();
    cyc(1'b1, 1'b0, 1'b0, ent(1'b0, 1'b0, 2'd0, m_sel, 1'b0, m_ok, m_fail));
    m_ok   = 1'b0;
    m_fail = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, ent(1'b1, 1'b0, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0));
    bus.ack = 1'b0;
    exp_q.push_back(ent(1'b1, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    chk("t033_call_before_reset", bus.call, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("t033_reset_mid_call");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_sel  = 4'd0;
    m_ok   = 1'b0;
    m_fail = 1'b0;
    idle(2);
    chk("t033_no_done_pulse", done_t.size(), 0);
    run_search(100, 2);
    idle(1);

    // Random callee behaviour with random delays and input noise.
    for (int k = 0; k < 30; k++) begin
      idle(int'($urandom_range(0, 3)));
      run_search(int'($urandom_range(20, 90)), 3);
    end
    idle(2);
    chk("expected_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/agenda_llamadas.md
AGENDA_LLAMADAS -- requirements
Module: agenda_llamadas

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a search; sampled only in IDLE.
REQ-005 ack  input  1  callee answered; sampled only in CALL.
REQ-006 resp  input  1  answer qualified by ack: 1 accept, 0 decline.
REQ-007 call  output  1  phone-call request, held high until ack is sampled.
REQ-008 who  output  2  callee index while call=1: 0 Ana, 1 Bea, 2 Carmen, 3 Diana.
REQ-009 sel  output  4  current candidate set {d,c,b,a}, bit i = person i invited.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at the end of a search.
REQ-012 ok  output  1  last search found a fully accepted valid set; held until next start.
REQ-013 fail  output  1  last search exhausted all candidates; held until next start.

Function
REQ-014 The block SHALL contain the invitation validity rule, valid(s) = at least one invited; not all four; b implies c; (a and c) implies (b or d); (c or d or not a) implies b, which gives the valid set {0001, 0110, 0111, 1110}.
REQ-015 The FSM SHALL have the states IDLE, CHECK, CALL, GAP, NEXT and DONE, with CHECK, GAP, NEXT and DONE each lasting exactly one cycle.
REQ-016 In IDLE with start=1 the FSM SHALL go to CHECK with sel=0001, clear ok and fail, and ignore start in every other state.
REQ-017 In CHECK, if valid(sel), the FSM SHALL go to CALL with who = the lowest set bit of sel; otherwise it SHALL go to NEXT.
REQ-018 In CALL the block SHALL hold call=1 and who stable, and SHALL stay in CALL until ack=1 is sampled, including ack already high in the first CALL cycle.
REQ-019 On ack with resp=1, if a higher set bit of sel remains, the FSM SHALL go to GAP (call=0) and then to CALL with who = the next higher set bit.
REQ-020 On ack with resp=1, if no higher set bit remains, the FSM SHALL go to DONE with ok=1.
REQ-021 On ack with resp=0, the FSM SHALL go to NEXT; calls already accepted are not retried.
REQ-022 In NEXT, if sel=1111, the FSM SHALL go to DONE with fail=1; otherwise sel SHALL increment and the FSM SHALL go to CHECK (no wrap-around).
REQ-023 In DONE, done SHALL be 1 for one cycle, then the FSM SHALL go to IDLE; sel keeps its final value until the next start.
REQ-024 ack and resp SHALL be ignored outside CALL, and call SHALL be 0 in every state except CALL.
REQ-025 ok and fail SHALL never both be 1.

Reset
REQ-026 While reset_n=0, regardless of clk, the block SHALL set state=IDLE, call=0, who=0, sel=0000, busy=0, done=0, ok=0 and fail=0.
REQ-027 A reset assertion mid-call SHALL drop call immediately (asynchronously), and the interrupted search SHALL be discarded with no done pulse.

Verification
REQ-028 start at T0, ack=1 resp=1 at T2 -> CHECK sel=0001 at T1, call=1 who=0 at T2, done=ok=1 sel=0001 at T3, IDLE at T4.
REQ-029 start at T0, Ana declines at T2 -> NEXT at T3, CHECK sel=0010 at T4, two cycles per invalid candidate, CALL who=1 sel=0110 at T13.
REQ-030 Continuing REQ-029, accept at T13 -> GAP call=0 at T14, CALL who=2 at T15, and accept there -> done=ok=1 sel=0110 at T16.
REQ-031 Every call declined -> calls occur in order to sel 0001, 0110, 0111 and 1110, then done=1 fail=1 ok=0 sel=1111.
REQ-032 start, ack and resp toggled while busy or in IDLE without a call -> no state change; ack held high during the GAP cycle has no effect.
REQ-033 reset_n pulsed low while call=1 -> all outputs at reset values before the next clk edge, and a later start restarts at sel=0001.
